// File: rtl/cbfp_shift_ctrl.sv
`timescale 1ns/1ps
// cbfp_shift_ctrl: turns per-block leading-zero counts into shifter
// commands through a descriptor FIFO and accumulates the frame exponent.
module cbfp_shift_ctrl #(
    parameter int CNT_W       = 5,
    parameter int Q_PT        = 12,
    parameter int MAX_RSH     = 22,
    parameter int BLK_PER_FRM = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int EXP_W       = 10
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [3:0][CNT_W-1:0]   cal_cnt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    shift_left,
    output logic [4:0]              shift_amt,
    output logic                    shift_sat,
    output logic                    out_last,
    output logic signed [EXP_W-1:0] frame_exp,
    output logic                    frame_exp_valid,
    output logic                    frame_err,
    output logic                    busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int BLK_W = $clog2(BLK_PER_FRM);

    localparam logic signed [EXP_W-1:0] QX       = EXP_W'(Q_PT);
    localparam logic signed [EXP_W-1:0] RX       = EXP_W'(MAX_RSH);
    localparam logic [BLK_W-1:0]        LAST_BLK = BLK_W'(BLK_PER_FRM - 1);
    localparam logic [PTR_W:0]          FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic       left;
        logic [4:0] amt;
        logic       sat;
        logic       last;
    } cmd_t;

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic signed [CNT_W-1:0] m;
    logic signed [EXP_W-1:0] m_x;
    logic signed [EXP_W-1:0] e;
    cmd_t                    cmd;
    cmd_t                    oc;

    cmd_t                    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [PTR_W:0]          cnt_q;
    logic [PTR_W:0]          cnt_d;
    logic                    rdy_q;
    logic                    full;
    logic                    push;
    logic                    pop;

    state_t                  state_q;
    logic signed [EXP_W-1:0] acc_q;
    logic [BLK_W-1:0]        blk_q;
    logic signed [EXP_W-1:0] frame_exp_q;
    logic                    fev_q;
    logic                    err_q;

    // Signed minimum of the four group counts
    always_comb begin
        m = $signed(cal_cnt[0]);
        for (int i = 1; i < 4; i++) begin
            if ($signed(cal_cnt[i]) < m) begin
                m = $signed(cal_cnt[i]);
            end
        end
    end

    // Shift command and unclamped block exponent from the block minimum
    always_comb begin
        m_x      = EXP_W'(m);
        e        = QX - m_x;
        cmd      = '0;
        cmd.last = in_last;
        if (m_x > QX) begin
            cmd.left = 1'b1;
            cmd.amt  = 5'(m_x - QX);
        end else if (e > RX) begin
            cmd.amt = 5'(RX);
            cmd.sat = 1'b1;
        end else begin
            cmd.amt = 5'(e);
        end
    end

    assign full      = (cnt_q == FULL_CNT);
    assign out_valid = (cnt_q != '0);
    assign in_ready  = rdy_q && !full;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Occupancy next state
    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Descriptor storage; an entry is only observed while it is valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd;
        end
    end

    // FIFO pointers, occupancy and the post-reset ready enable
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            cnt_q <= cnt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign oc         = out_valid ? mem_q[rd_ptr_q] : '0;
    assign shift_left = oc.left;
    assign shift_amt  = oc.amt;
    assign shift_sat  = oc.sat;
    assign out_last   = oc.last;

    // Frame tracking: block count, exponent accumulation, error flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            blk_q       <= '0;
            frame_exp_q <= '0;
            fev_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            fev_q <= 1'b0;
            if (push) begin
                if (in_last) begin
                    state_q     <= IDLE;
                    frame_exp_q <= acc_q + e;
                    fev_q       <= 1'b1;
                    acc_q       <= '0;
                    blk_q       <= '0;
                    if (blk_q != LAST_BLK) begin
                        err_q <= 1'b1;
                    end
                end else begin
                    state_q <= ACTIVE;
                    acc_q   <= acc_q + e;
                    if (blk_q == LAST_BLK) begin
                        err_q <= 1'b1;
                        blk_q <= '0;
                    end else begin
                        blk_q <= blk_q + 1'b1;
                    end
                end
            end
        end
    end

    assign frame_exp       = frame_exp_q;
    assign frame_exp_valid = fev_q;
    assign frame_err       = err_q;
    assign busy            = (state_q == ACTIVE) || out_valid;

endmodule
